// File: rtl/simplecpu_param.sv
// simplecpu_param: parametrised accumulator CPU.
// The IDLE/FETCH/EXEC/ALU/HALT state machine runs a program from an on-chip
// word memory that is filled through the program-load port.
// Optional feature: define SIMPLECPU_STEP_EN to add the `step` input and a
// PAUSE state. In PAUSE the CPU waits between instructions for a step pulse.
module simplecpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_ram,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run,
`ifdef SIMPLECPU_STEP_EN
  input  logic              step,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_zero,
  output logic              flag_carry
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_ALU   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
`ifdef SIMPLECPU_STEP_EN
  localparam logic [2:0] S_PAUSE = 3'd5;
  // Where a completed instruction goes: wait for a step pulse.
  localparam logic [2:0] S_DONE  = S_PAUSE;
`else
  // Where a completed instruction goes: straight to the next fetch.
  localparam logic [2:0] S_DONE  = S_FETCH;
`endif

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        ir_op_q, ir_op_d;
  logic [ADDR_W-1:0] ir_arg_q, ir_arg_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] operand_word;
  logic              is_sub;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_sum;

  // Asynchronous read of the operand word; a write shows up on the next cycle.
  assign operand_word = mem[ir_arg_q];
  assign pc_inc       = pc_q + ADDR_W'(1);

  // SUB is computed as A + ~B + 1, so the carry out means "no borrow".
  assign is_sub  = (ir_op_q == OP_SUB);
  assign alu_b   = is_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};

  // Next-state and datapath decode for every state of the machine.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // a value unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_op_d     = ir_op_q;
    ir_arg_d    = ir_arg_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = load_addr;
    mem_wdata   = load_data;

    case (state_q)
      S_IDLE: begin
        mem_we = load_ram;
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Only the opcode and operand fields are kept; the middle bits are dropped.
        ir_op_d  = mem[pc_q][DATA_W-1 -: 4];
        ir_arg_d = mem[pc_q][ADDR_W-1:0];
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        case (ir_op_q)
          OP_LDA: begin
            a_d     = operand_word;
            pc_d    = pc_inc;
            state_d = S_DONE;
          end
          OP_ADD, OP_SUB: begin
            b_d     = operand_word;
            state_d = S_ALU;
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = ir_arg_q;
            mem_wdata = a_q;
            pc_d      = pc_inc;
            state_d   = S_DONE;
          end
          OP_LDI: begin
            a_d     = DATA_W'(ir_arg_q);
            pc_d    = pc_inc;
            state_d = S_DONE;
          end
          OP_JMP: begin
            pc_d    = ir_arg_q;
            state_d = S_DONE;
          end
          OP_JZ: begin
            pc_d    = z_q ? ir_arg_q : pc_inc;
            state_d = S_DONE;
          end
          OP_JC: begin
            pc_d    = c_q ? ir_arg_q : pc_inc;
            state_d = S_DONE;
          end
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
            state_d     = S_DONE;
          end
          OP_HLT: begin
            state_d = S_HALT;
          end
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = S_DONE;
          end
          default: begin
            // Opcodes B..F behave as NOP.
            pc_d    = pc_inc;
            state_d = S_DONE;
          end
        endcase
      end

      S_ALU: begin
        a_d     = alu_sum[DATA_W-1:0];
        c_d     = alu_sum[DATA_W];
        z_d     = (alu_sum[DATA_W-1:0] == '0);
        pc_d    = pc_inc;
        state_d = S_DONE;
      end

      S_HALT: begin
        mem_we = load_ram;
        if (run) begin
          pc_d    = '0;
          a_d     = '0;
          b_d     = '0;
          z_d     = 1'b0;
          c_d     = 1'b0;
          state_d = S_FETCH;
        end
      end

`ifdef SIMPLECPU_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Architectural registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_op_q     <= '0;
      ir_arg_q    <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_op_q     <= ir_op_d;
      ir_arg_q    <= ir_arg_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Program/data memory write port, shared by STA and the load port.
  always_ff @(posedge clk) begin
    // NOTE: memory has no reset on purpose; a loaded program survives reset
    // and the array maps onto plain RAM.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign halted     = (state_q == S_HALT);
  assign pc         = pc_q;
  assign flag_zero  = z_q;
  assign flag_carry = c_q;

endmodule
